// File: rtl/ram_fifo_pkg.sv
// Shared sizing helpers for the RAM-backed FIFO controller and its output buffer.
package ram_fifo_pkg;

    localparam int unsigned OBUF_DEPTH = 2;
    localparam int unsigned OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);

    // Total words the FIFO can hold: full RAM plus the output buffer.
    function automatic int unsigned fifo_capacity(input int unsigned adr_w);
        return (32'd1 << adr_w) + OBUF_DEPTH;
    endfunction

    // Width of the occupancy count, wide enough for fifo_capacity().
    function automatic int unsigned count_width(input int unsigned adr_w);
        return adr_w + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry show-ahead output buffer fed by registered RAM read data.
module ram_fifo_obuf
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    input  logic                  i_capture,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [OBUF_CNT_W-1:0] o_cnt
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [OBUF_CNT_W-1:0] r_cnt;

    // The upstream issue guard guarantees no capture arrives while full without a pop.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_cnt)
                OBUF_CNT_W'(0): begin
                    if (i_capture) begin
                        r_head <= i_data;
                        r_cnt  <= OBUF_CNT_W'(1);
                    end
                end
                OBUF_CNT_W'(1): begin
                    case ({i_capture, i_pop})
                        2'b10: begin
                            r_tail <= i_data;
                            r_cnt  <= OBUF_CNT_W'(OBUF_DEPTH);
                        end
                        2'b01: r_cnt  <= OBUF_CNT_W'(0);
                        2'b11: r_head <= i_data;
                        default: ;
                    endcase
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_capture) begin
                            r_tail <= i_data;
                        end else begin
                            r_cnt <= OBUF_CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_cnt != '0);
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external 1-cycle-latency dual-port RAM.
// Optional synchronous FLUSH input is enabled by defining RAM_FIFO_FLUSH_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADR_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic                  FLUSH,
`endif
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [ADR_WIDTH+1:0]  COUNT,
    output logic                  RAM_WEN,
    output logic [ADR_WIDTH-1:0]  RAM_WADR,
    output logic [DATA_WIDTH-1:0] RAM_WDAT,
    output logic [ADR_WIDTH-1:0]  RAM_RADR,
    input  logic [DATA_WIDTH-1:0] RAM_RDAT
);

    localparam int unsigned RAM_DEPTH = 32'd1 << ADR_WIDTH;
    localparam int unsigned CNT_W     = count_width(ADR_WIDTH);

    logic [ADR_WIDTH-1:0]  r_wptr;
    logic [ADR_WIDTH-1:0]  r_rptr;
    logic [ADR_WIDTH:0]    r_ram_cnt;
    logic                  r_inflight;
    logic [CNT_W-1:0]      r_count;
    logic [OBUF_CNT_W-1:0] w_buf_cnt;
    logic [2:0]            w_occ;
    logic                  w_clr;
    logic                  w_not_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;

    assign w_not_full = (r_ram_cnt < (ADR_WIDTH+1)'(RAM_DEPTH));

`ifdef RAM_FIFO_FLUSH_EN
    assign w_clr    = !RST_N || FLUSH;
    assign IN_READY = RST_N && !FLUSH && w_not_full;
`else
    assign w_clr    = !RST_N;
    assign IN_READY = RST_N && w_not_full;
`endif

    assign w_push = IN_VALID && IN_READY;
    assign w_pop  = OUT_VALID && OUT_READY;

    // Issue a read only if the word will have a buffer slot when it lands.
    assign w_occ   = 3'(w_buf_cnt) + 3'(r_inflight);
    assign w_issue = (r_ram_cnt != '0) && (w_occ < (3'd2 + 3'(w_pop)));

    assign RAM_WEN  = w_push;
    assign RAM_WADR = r_wptr;
    assign RAM_WDAT = IN_DATA;
    assign RAM_RADR = r_rptr;
    assign COUNT    = r_count;

    always_ff @(posedge CLK) begin
        if (w_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wptr     <= r_wptr + ADR_WIDTH'(w_push);
            r_rptr     <= r_rptr + ADR_WIDTH'(w_issue);
            r_inflight <= w_issue;
            if (w_push && !w_issue) begin
                r_ram_cnt <= r_ram_cnt + (ADR_WIDTH+1)'(1);
            end else if (!w_push && w_issue) begin
                r_ram_cnt <= r_ram_cnt - (ADR_WIDTH+1)'(1);
            end
            // Total occupancy only changes at the FIFO boundaries.
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    ram_fifo_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .i_clk    (CLK),
        .i_clr    (w_clr),
        .i_capture(r_inflight),
        .i_data   (RAM_RDAT),
        .i_pop    (w_pop),
        .o_data   (OUT_DATA),
        .o_valid  (OUT_VALID),
        .o_cnt    (w_buf_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with ADR_WIDTH=2 and a registered-read RAM model.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       ram_wen;
    logic [1:0] ram_wadr;
    logic [7:0] ram_wdat;
    logic [1:0] ram_radr;
    logic [7:0] ram_rdat;
    logic [7:0] mem [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(8), .ADR_WIDTH(2)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
`ifdef RAM_FIFO_FLUSH_EN
        .FLUSH    (flush),
`endif
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .IN_DATA  (in_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .OUT_DATA (out_data),
        .COUNT    (count),
        .RAM_WEN  (ram_wen),
        .RAM_WADR (ram_wadr),
        .RAM_WDAT (ram_wdat),
        .RAM_RADR (ram_radr),
        .RAM_RDAT (ram_rdat)
    );

    always @(posedge clk) begin
        if (ram_wen) mem[ram_wadr] <= ram_wdat;
        ram_rdat <= mem[ram_radr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0; flush = 1'b0;
        tick; tick;
        @(negedge clk);
        checks += 5;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        if (ram_wen !== 1'b0) begin errors++; $display("FAIL reset_ram_wen: got %b expected 0", ram_wen); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        tick;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        tick;
    endtask

    task automatic test_single_push;
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
        if (ram_wen !== 1'b1) begin errors++; $display("FAIL single_ram_wen: got %b expected 1", ram_wen); end
        if (ram_wadr !== 2'd0) begin errors++; $display("FAIL single_wadr: got %0d expected 0", ram_wadr); end
        tick;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            out_ready = (cyc == 4);
            @(negedge clk);
            checks += 2;
            if (count !== 4'd1) begin errors++; $display("FAIL single_count c%0d: got %0d expected 1", cyc, count); end
            if (out_valid !== (cyc >= 3)) begin errors++; $display("FAIL single_valid c%0d: got %b expected %b", cyc, out_valid, cyc >= 3); end
            if (cyc >= 3) begin
                checks++;
                if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data c%0d: got %h expected a5", cyc, out_data); end
            end
            tick;
        end
        out_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (count !== 4'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_pop: got %b expected 0", out_valid); end
        tick;
    endtask

    task automatic test_fill;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1);
            @(negedge clk);
            checks += 2;
            if (in_ready !== (i < 6)) begin errors++; $display("FAIL fill_in_ready w%0d: got %b expected %b", i, in_ready, i < 6); end
            if (ram_wen !== (i < 6)) begin errors++; $display("FAIL fill_ram_wen w%0d: got %b expected %b", i, ram_wen, i < 6); end
            tick;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (count !== 4'd6) begin errors++; $display("FAIL fill_count: got %0d expected 6", count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full: got %b expected 0", in_ready); end
        tick;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k + 1)) begin
                errors++; $display("FAIL fill_drain w%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, 8'(k + 1));
            end
            tick;
        end
        @(negedge clk);
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL fill_count_drained: got %0d expected 0", count); end
        out_ready = 1'b0;
        tick;
    endtask

    task automatic test_streaming;
        int sent = 0;
        int rcv = 0;
        int first = -1;
        int last = -1;
        logic pushed;
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            pushed = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (out_data !== 8'(rcv)) begin errors++; $display("FAIL stream_data w%0d: got %h expected %h", rcv, out_data, 8'(rcv)); end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            tick;
            if (pushed) sent++;
            in_data = 8'(sent);
            in_valid = (sent < 20);
        end
        checks += 6;
        if (sent != 20) begin errors++; $display("FAIL stream_sent: got %0d expected 20", sent); end
        if (rcv != 20) begin errors++; $display("FAIL stream_rcv: got %0d expected 20", rcv); end
        if (first != 3) begin errors++; $display("FAIL stream_first: got %0d expected 3", first); end
        if (last != 22) begin errors++; $display("FAIL stream_last: got %0d expected 22", last); end
        // 7 earlier writes plus 20 here: both pointers end at 27 mod 4.
        if (ram_wadr !== 2'd3) begin errors++; $display("FAIL stream_wadr: got %0d expected 3", ram_wadr); end
        if (ram_radr !== 2'd3) begin errors++; $display("FAIL stream_radr: got %0d expected 3", ram_radr); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int sent = 0;
        int rcv = 0;
        int mc = 0;
        int cyc = 0;
        while (rcv < 1000 && cyc < 20000) begin
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks += 2;
            if (count !== 4'(mc)) begin errors++; $display("FAIL bp_count c%0d: got %0d expected %0d", cyc, count, mc); end
            if (count > 4'd6) begin errors++; $display("FAIL bp_count_max c%0d: got %0d expected <=6", cyc, count); end
            if (mc == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_empty c%0d: got %b expected 0", cyc, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_pop_empty c%0d: got %h expected no data", cyc, out_data);
                end else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin errors++; $display("FAIL bp_data w%0d: got %h expected %h", rcv, out_data, exp_d); end
                    mc--;
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
                mc++;
            end
            tick;
            cyc++;
        end
        checks++;
        if (rcv != 1000) begin errors++; $display("FAIL bp_timeout: got %0d words expected 1000", rcv); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
            tick;
        end
        in_valid = 1'b1; in_data = 8'h14; out_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (count !== 4'd4) begin errors++; $display("FAIL mid_count_pre: got %0d expected 4", count); end
        if (out_valid !== 1'b1 || out_data !== 8'h10) begin errors++; $display("FAIL mid_head: got v=%b d=%h expected v=1 d=10", out_valid, out_data); end
        tick;
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if (count !== 4'd4) begin errors++; $display("FAIL mid_count_inflight: got %0d expected 4", count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready_rst: got %b expected 0", in_ready); end
        tick;
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after: got %b expected 0", out_valid); end
        if (count !== 4'd0) begin errors++; $display("FAIL mid_count_after: got %0d expected 0", count); end
        tick;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (out_data !== 8'h3C) begin errors++; $display("FAIL mid_first_word: got %h expected 3c", out_data); end
            end
            tick;
        end
        checks += 2;
        if (!seen) begin errors++; $display("FAIL mid_timeout: got no word expected 3c"); end
        @(negedge clk);
        if (count !== 4'd0) begin errors++; $display("FAIL mid_count_end: got %0d expected 0", count); end
        out_ready = 1'b0;
        tick;
    endtask

`ifdef RAM_FIFO_FLUSH_EN
    task automatic test_flush;
        bit seen = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h50 + i);
            tick;
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        checks += 3;
        if (count !== 4'd5) begin errors++; $display("FAIL flush_count_pre: got %0d expected 5", count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        if (ram_wen !== 1'b0) begin errors++; $display("FAIL flush_ram_wen: got %b expected 0", ram_wen); end
        tick;
        flush = 1'b0; in_valid = 1'b1; in_data = 8'h42;
        @(negedge clk);
        checks += 2;
        if (count !== 4'd0) begin errors++; $display("FAIL flush_count_after: got %0d expected 0", count); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_after: got %b expected 0", out_valid); end
        tick;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (out_data !== 8'h42) begin errors++; $display("FAIL flush_first_word: got %h expected 42", out_data); end
            end
            tick;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL flush_timeout: got no word expected 42"); end
        out_ready = 1'b0;
        tick;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        test_reset;
        test_single_push;
        test_fill;
        test_streaming;
        test_backpressure;
        test_reset_mid;
`ifdef RAM_FIFO_FLUSH_EN
        test_flush;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Valid/ready FIFO controller that drives an external simple dual-port RAM (registered read, 1-cycle latency) as its storage and presents a show-ahead stream interface.
- Sits upstream of the RAM: it generates write enable, write/read addresses and write data, and consumes the registered read data.
- Used for UART RX/TX and bus buffering on the MAX1000 design.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADR_WIDTH, 8, RAM address width. RAM depth is 2^ADR_WIDTH; total FIFO capacity is 2^ADR_WIDTH + 2.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- IN_VALID  in  1  producer offers IN_DATA.
- IN_READY  out  1  controller can accept a word.
- IN_DATA  in  DATA_WIDTH  write word.
- OUT_VALID  out  1  OUT_DATA holds the FIFO head.
- OUT_READY  in  1  consumer takes the head.
- OUT_DATA  out  DATA_WIDTH  head word.
- COUNT  out  ADR_WIDTH+2  total words held (RAM + in-flight + output buffer).
- RAM_WEN  out  1  to RAM write enable.
- RAM_WADR  out  ADR_WIDTH  to RAM write address.
- RAM_WDAT  out  DATA_WIDTH  to RAM write data.
- RAM_RADR  out  ADR_WIDTH  to RAM read address.
- RAM_RDAT  in  DATA_WIDTH  from RAM registered read data.

Behaviour:
- Interface decision: one clock, CLK; reset RST_N is synchronous and active-low.
- Reset state: wptr = rptr = 0, ram_cnt = 0, inflight = 0, output buffer (2 entries) empty.
  - OUT_VALID = 0, OUT_DATA = 0, COUNT = 0, RAM_WEN = 0.
  - IN_READY is held 0 while RST_N = 0 and is 1 in the first cycle after release.
- Write side:
  - push = IN_VALID & IN_READY.
  - IN_READY = RST_N & (ram_cnt < 2^ADR_WIDTH), computed from registered state only; no combinational path from OUT_READY.
  - RAM_WEN = push, RAM_WADR = wptr, RAM_WDAT = IN_DATA.
  - wptr increments on push and wraps modulo 2^ADR_WIDTH.
- Read issue:
  - pop = OUT_VALID & OUT_READY.
  - issue = (ram_cnt != 0) & (buf_cnt + inflight - pop < 2).
  - RAM_RADR = rptr at all times. rptr increments on issue and wraps.
  - inflight (0/1) is set on issue and cleared next cycle, when RAM_RDAT is captured into the buffer tail.
- ram_cnt_next = ram_cnt + push - issue. Simultaneous push and issue leaves ram_cnt unchanged.
- Output buffer:
  - 2-entry FIFO; head drives OUT_DATA (registered); OUT_VALID = buf_cnt != 0.
  - Capture and pop in the same cycle are legal.
  - When the buffer is empty and data is captured, the captured word becomes the head.
- Latency:
  - Word accepted in cycle N: RAM write at the end of N, read issued in N+1, captured at the end of N+2, OUT_VALID in N+3.
  - Steady-state throughput is 1 word/cycle with OUT_READY held high.
- Full:
  - IN_READY = 0 when ram_cnt = 2^ADR_WIDTH.
  - A read issued while full frees a slot only in the next cycle.
  - wptr = rptr when full, but no write can occur, so there is no same-address hazard.
- Empty: OUT_VALID = 0; OUT_READY is ignored; no issue occurs.
- Pointer wrap: after 2^ADR_WIDTH writes, wptr returns to 0 with data order preserved.
- Reset mid-operation: all state is cleared on the next edge, and any in-flight RAM_RDAT is discarded.
  - RAM contents are not cleared and are never observed stale, because pointers restart together.
- COUNT = ram_cnt + inflight + buf_cnt, registered-state sum. Maximum is 2^ADR_WIDTH + 2.

Optional Feature:
- Macro RAM_FIFO_FLUSH_EN.
- When defined:
  - Adds input FLUSH (1 bit), a synchronous clear with the same effect as reset on pointers, counts, buffer and inflight.
  - IN_READY = 0 and RAM_WEN = 0 during the FLUSH cycle; a simultaneous push is dropped.
  - FLUSH is ignored while RST_N = 0.
- When undefined: the FLUSH port does not exist and there is no flush logic.

Decomposition:
- Shared package ram_fifo_pkg:
  - localparams for capacity (2^ADR_WIDTH + 2) and COUNT width.
  - Output-buffer depth constant OBUF_DEPTH = 2.
- One sub-module is natural: ram_fifo_obuf, the 2-entry output buffer with capture/pop/count. The pointer, ram_cnt and issue logic stays in the top module.
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan (ADR_WIDTH = 2, DATA_WIDTH = 8, bench RAM model with 1-cycle registered read):
- Reset then single push:
  - Stimulus: release RST_N, push 0xA5 in cycle 0.
  - Required: IN_READY = 1 in the first cycle after release; OUT_VALID rises in cycle 3 with OUT_DATA = 0xA5; COUNT goes 1,1,1,1 and then 0 after pop.
- Fill to capacity:
  - Stimulus: OUT_READY = 0, push 0x01..0x08 continuously.
  - Required: exactly 6 accepted (0x01..0x06); IN_READY low afterwards; COUNT = 6; RAM_WEN never asserted when IN_READY = 0.
- Streaming:
  - Stimulus: IN_VALID and OUT_READY both held high, 20 incrementing words 0x00..0x13.
  - Required: outputs appear in order, one per cycle after the 3-cycle fill; pointers wrap 5 times with no loss.
- Backpressure toggling:
  - Stimulus: random IN_VALID and OUT_READY over 1000 words.
  - Required: the scoreboard matches order and content; COUNT is never greater than 6; no pop occurs while OUT_VALID = 0.
- Reset mid-operation:
  - Stimulus: with COUNT = 4 and a read in flight, pulse RST_N low for 1 cycle.
  - Required: next cycle OUT_VALID = 0 and COUNT = 0; the following push of 0x3C emerges first.
- RAM_FIFO_FLUSH_EN:
  - Stimulus: with COUNT = 5, assert FLUSH while pushing 0x77.
  - Required: 0x77 is dropped; next cycle COUNT = 0 and OUT_VALID = 0; normal operation resumes.
